// File: rtl/lsu_mmio.sv
// lsu_mmio: byte/half/word load-store unit over a synchronous data RAM and
// memory-mapped LED/HEX/LCD, synchronised switch/button, button-edge and cycle-counter registers.
module lsu_mmio #(
  parameter logic [15:0] DMEM_BASE = 16'h2000,
  parameter int DMEM_WORDS = 2048,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_ack,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic [15:0] off, wa;
  logic        err, ram_hit, wr, reg_wr, clr, unused_hi;
  logic [3:0]  be;
  logic [31:0] wd, reg_rd;
  logic [SYNC_STAGES-1:0][31:0] sw_q;
  logic [SYNC_STAGES-1:0][3:0]  btn_q;
  logic [31:0] sw_s;
  logic [3:0]  btn_s, btn_prev, edge_q;
  logic [31:0] hex_lo, hex_hi, cnt;
  logic [31:0] mem [DMEM_WORDS];
  logic [31:0] ram_rd, reg_q, word, sh, ext;
  logic        ack_q, err_q, ld_q, ram_q, uns_q;
  logic [1:0]  lane_q, size_q;

  assign off       = i_addr[15:0];
  assign wa        = {off[15:2], 2'b00};
  assign unused_hi = ^i_addr[31:16];
  assign ram_hit   = off[15:AW+2] == DMEM_BASE[15:AW+2];
  assign sw_s      = sw_q[SYNC_STAGES-1];
  assign btn_s     = btn_q[SYNC_STAGES-1];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = m[i] ? nw[8*i+:8] : old[8*i+:8];
    return r;
  endfunction

  always_comb begin
    err    = i_size == 2'b11 || (i_size == 2'b01 && off[0]) || (i_size == 2'b10 && off[1:0] != 2'b00);
    be     = i_size == 2'b00 ? 4'b0001 << off[1:0] : i_size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd     = i_size == 2'b00 ? {4{i_wdata[7:0]}} : i_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
    wr     = i_req && i_we && !err;
    reg_wr = wr && !ram_hit;
    // only word loads or byte loads of lane 0 acknowledge the captured edges
    clr    = i_req && !i_we && !err && !ram_hit && wa == 16'h7814 &&
             (i_size == 2'b10 || (i_size == 2'b00 && off[1:0] == 2'b00));
    reg_rd = wa == 16'h7000 ? o_io_ledr :
             wa == 16'h7010 ? o_io_ledg :
             wa == 16'h7020 ? hex_lo :
             wa == 16'h7024 ? hex_hi :
             wa == 16'h7030 ? o_io_lcd :
             wa == 16'h7800 ? sw_s :
             wa == 16'h7810 ? {28'h0, btn_s} :
             wa == 16'h7814 ? {28'h0, edge_q} :
             wa == 16'h7820 ? cnt : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q      <= '0;
      btn_q     <= '0;
      btn_prev  <= '0;
      edge_q    <= '0;
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
      hex_lo    <= '0;
      hex_hi    <= '0;
      cnt       <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ld_q      <= 1'b0;
      ram_q     <= 1'b0;
      uns_q     <= 1'b0;
      lane_q    <= '0;
      size_q    <= '0;
      reg_q     <= '0;
    end else begin
      sw_q      <= {sw_q[SYNC_STAGES-2:0], i_io_sw};
      btn_q     <= {btn_q[SYNC_STAGES-2:0], i_io_btn};
      btn_prev  <= btn_s;
      edge_q    <= (edge_q & ~{4{clr}}) | (btn_s & ~btn_prev);
      if (reg_wr && wa == 16'h7000) o_io_ledr <= merge(o_io_ledr, wd, be);
      if (reg_wr && wa == 16'h7010) o_io_ledg <= merge(o_io_ledg, wd, be);
      if (reg_wr && wa == 16'h7020) hex_lo <= merge(hex_lo, wd & 32'h7F7F7F7F, be);
      if (reg_wr && wa == 16'h7024) hex_hi <= merge(hex_hi, wd & 32'h7F7F7F7F, be);
      if (reg_wr && wa == 16'h7030) o_io_lcd <= merge(o_io_lcd, wd, be);
      cnt       <= reg_wr && wa == 16'h7820 ? merge(cnt, wd, be) : cnt + 32'd1;
      ack_q     <= i_req;
      err_q     <= i_req && err;
      ld_q      <= i_req && !i_we && !err;
      ram_q     <= ram_hit;
      uns_q     <= i_unsigned;
      lane_q    <= off[1:0];
      size_q    <= i_size;
      reg_q     <= reg_rd;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr && ram_hit && be[i]) mem[off[AW+1:2]][8*i+:8] <= wd[8*i+:8];
    ram_rd <= mem[off[AW+1:2]];
  end

  always_comb begin
    word = ram_q ? ram_rd : reg_q;
    sh   = word >> {lane_q, 3'b000};
    ext  = size_q == 2'b00 ? {{24{!uns_q && sh[7]}}, sh[7:0]} :
           size_q == 2'b01 ? {{16{!uns_q && sh[15]}}, sh[15:0]} : sh;
  end

  assign o_ack     = ack_q;
  assign o_err     = err_q;
  assign o_rdata   = ld_q ? ext : 32'h0;
  assign o_io_hex0 = hex_lo[6:0];
  assign o_io_hex1 = hex_lo[14:8];
  assign o_io_hex2 = hex_lo[22:16];
  assign o_io_hex3 = hex_lo[30:24];
  assign o_io_hex4 = hex_hi[6:0];
  assign o_io_hex5 = hex_hi[14:8];
  assign o_io_hex6 = hex_hi[22:16];
  assign o_io_hex7 = hex_hi[30:24];
endmodule
